// File: rtl/multicycle_ctrl.sv
// Control unit for the 16-bit multicycle core.
// Holds the state, instruction and Z/C flag registers, handshakes with
// instruction and data memories that may stall, applies conditional
// writeback, traps on illegal opcodes or memory timeouts, and counts
// retired instructions.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          imem_rdata,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 alu_zero,
    input  logic                 alu_carry,
    output logic [2:0]           state,
    output logic [15:0]          ir,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic [1:0]           alu_ctrl,
    output logic                 alu_src,
    output logic                 reg_dst,
    output logic [1:0]           wb_sel,
    output logic                 reg_we,
    output logic                 z_flag,
    output logic                 c_flag,
    output logic [CNT_WIDTH-1:0] retired,
    output logic                 trap,
    output logic [1:0]           trap_cause
);

    localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_TRAP  = 3'd7
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b1010;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_JAL  = 4'b1101;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JAL = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    state_e               state_q, state_d;
    logic [15:0]          ir_q, ir_d;
    logic                 z_q, z_d;
    logic                 c_q, c_d;
    logic                 cond_q, cond_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 trap_q, trap_d;
    logic [1:0]           cause_q, cause_d;

    logic       stall;
    logic       trap_req;
    logic [1:0] trap_why;

    logic [3:0] op_q;
    logic       is_add, is_nand, is_alu, is_lw, is_sw, is_beq, is_jal;
    logic       cond_c;
    logic       wait_last;
    logic [3:0] fetch_op;
    logic       fetch_cc_bad;

    assign op_q    = ir_q[15:12];
    assign is_add  = (op_q == OP_ADD);
    assign is_nand = (op_q == OP_NAND);
    assign is_alu  = is_add | is_nand;
    assign is_lw   = (op_q == OP_LW);
    assign is_sw   = (op_q == OP_SW);
    assign is_beq  = (op_q == OP_BEQ);
    assign is_jal  = (op_q == OP_JAL);

    // Writeback predicate from the latched flags: 00 always, 10 on carry, 01 on zero
    assign cond_c = (ir_q[1:0] == 2'b00)
                  | ((ir_q[1:0] == 2'b10) & c_q)
                  | ((ir_q[1:0] == 2'b01) & z_q);

    // The pending request times out on the edge where the count would reach TIMEOUT
    assign wait_last = (TIMEOUT != 0) && ((32'(wait_q) + 32'd1) == TIMEOUT);

    assign fetch_op     = imem_rdata[15:12];
    assign fetch_cc_bad = (imem_rdata[1:0] == 2'b11);

    // Next-state, datapath enables and bookkeeping for the current cycle
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        z_d       = z_q;
        c_d       = c_q;
        cond_d    = cond_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        stall     = 1'b0;
        trap_req  = 1'b0;
        trap_why  = CAUSE_NONE;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SEQ;
        alu_ctrl  = ALU_ADD;
        alu_src   = 1'b0;
        reg_dst   = 1'b0;
        wb_sel    = WB_ALU;
        reg_we    = 1'b0;
        retired_d = retired_q;
        wait_d    = wait_q;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d = imem_rdata;
                    case (fetch_op)
                        OP_ADD, OP_NAND: begin
                            if (fetch_cc_bad) begin
                                trap_req = 1'b1;
                                trap_why = CAUSE_ILLEGAL;
                            end else begin
                                state_d = S_EXEC;
                            end
                        end
                        OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
                        OP_JAL:               state_d = S_WB;
                        default: begin
                            trap_req = 1'b1;
                            trap_why = CAUSE_ILLEGAL;
                        end
                    endcase
                end else if (wait_last) begin
                    trap_req = 1'b1;
                    trap_why = CAUSE_IMEM_TO;
                end else begin
                    stall = 1'b1;
                end
            end

            S_EXEC: begin
                if (is_alu) begin
                    alu_ctrl = is_nand ? ALU_NAND : ALU_ADD;
                    cond_d   = cond_c;
                    if (cond_c) begin
                        z_d = alu_zero;
                        if (is_add) begin
                            c_d = alu_carry;
                        end
                    end
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_ctrl = ALU_ADD;
                    alu_src  = 1'b1;
                    state_d  = S_MEM;
                end else if (is_beq) begin
                    alu_ctrl = ALU_SUB;
                    pc_we    = 1'b1;
                    pc_src   = alu_zero ? PC_BR : PC_SEQ;
                    state_d  = S_FETCH;
                end else begin
                    trap_req = 1'b1;
                    trap_why = CAUSE_ILLEGAL;
                end
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ready) begin
                    if (is_sw) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        trap_req = 1'b1;
                        trap_why = CAUSE_ILLEGAL;
                    end
                end else if (wait_last) begin
                    trap_req = 1'b1;
                    trap_why = CAUSE_DMEM_TO;
                end else begin
                    stall = 1'b1;
                end
            end

            S_WB: begin
                if (is_jal) begin
                    wb_sel  = WB_PC;
                    pc_src  = PC_JAL;
                    reg_we  = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end else if (is_lw) begin
                    wb_sel  = WB_MEM;
                    reg_we  = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end else if (is_alu) begin
                    wb_sel  = WB_ALU;
                    reg_dst = 1'b1;
                    reg_we  = cond_q;
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    trap_req = 1'b1;
                    trap_why = CAUSE_ILLEGAL;
                end
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                trap_req = 1'b1;
                trap_why = CAUSE_ILLEGAL;
            end
        endcase

        if (trap_req) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = trap_why;
        end

        if (pc_we) begin
            retired_d = retired_q + CNT_WIDTH'(1);
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (stall && (wait_q != {WAIT_W{1'b1}})) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Architectural registers of the controller
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            cond_q    <= 1'b0;
            retired_q <= '0;
            wait_q    <= '0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            z_q       <= z_d;
            c_q       <= c_d;
            cond_q    <= cond_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    assign state      = state_q;
    assign ir         = ir_q;
    assign z_flag     = z_q;
    assign c_flag     = c_q;
    assign retired    = retired_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Parametrised successor to the fixed 4-state sequencer of the 16-bit multicycle core.
- Owns the state register, the instruction register and the Z/C flag registers.
- Handshakes with instruction and data memories that may insert wait states, and applies ADC/ADZ/NDC/NDZ conditional writeback using the latched flags.
- Traps on illegal opcodes and on memory timeouts, and counts retired instructions; the datapath (PC, regfile, ALU, muxes) is driven by its enables.

Parameters:
- TIMEOUT, 15: max consecutive not-ready cycles per memory request; 0 disables timeout.
- CNT_WIDTH, 16: width of the retired-instruction counter.
- WAIT_W, $clog2(TIMEOUT+1) (min 1): width of the wait counter, derived.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_rdata  in  16  instruction memory read data
- imem_ready  in  1  imem_rdata valid this cycle
- dmem_ready  in  1  data access completes this cycle
- alu_zero  in  1  ALU zero, combinational, valid in EXEC
- alu_carry  in  1  ALU carry, combinational, valid in EXEC
- state  out  3  current state
- ir  out  16  latched instruction
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (qualifies dmem_req)
- pc_we  out  1  PC load, exactly one cycle per retired instruction
- pc_src  out  2  00 PC+2, 01 branch target, 10 JAL target
- alu_ctrl  out  2  00 add, 01 sub, 10 nand
- alu_src  out  1  1 selects sign-extended imm6
- reg_dst  out  1  1 selects ir[5:3], 0 selects ir[11:9]
- wb_sel  out  2  00 ALU, 01 memory, 10 PC+2
- reg_we  out  1  register write
- z_flag  out  1  latched zero flag
- c_flag  out  1  latched carry flag
- retired  out  CNT_WIDTH  retired-instruction count, wraps
- trap  out  1  sticky trap indicator
- trap_cause  out  2  01 illegal op, 10 imem timeout, 11 dmem timeout

Behaviour:
- Reset (async, any state): state=FETCH, ir=0, z_flag=c_flag=0, retired=0, wait counter=0, trap=0, trap_cause=00.
- State encoding: FETCH=0, EXEC=1, MEM=2, WB=3, TRAP=7. State 4–6 is unreachable; if entered, go to TRAP with cause 01.
- Outputs are combinational from state, ir, flags and inputs. Any control output not asserted by the current state is 0.
- FETCH:
  - imem_req=1.
  - On an edge with imem_ready=1: ir<=imem_rdata, decode imem_rdata[15:12]:
    - 0000 (ADD family), 0010 (NAND family), 1010 (LW), 1001 (SW), 1011 (BEQ) -> EXEC.
    - 1101 (JAL) -> WB.
    - Other opcode, or ADD/NAND with [1:0]=11 -> TRAP, cause 01.
- EXEC:
  - ADD/NAND: alu_ctrl 00/10, alu_src=0 -> WB.
  - LW/SW: alu_ctrl=00, alu_src=1 -> MEM.
  - BEQ: alu_ctrl=01, pc_we=1, pc_src=01 if alu_zero else 00 -> FETCH.
- Conditional write (cond), evaluated in EXEC and held in WB from registered flags:
  - ir[1:0]=00: always.
  - 10: c_flag=1.
  - 01: z_flag=1.
  - On the EXEC→WB edge, if cond: z_flag<=alu_zero. For ADD only, also c_flag<=alu_carry. If not cond: flags unchanged.
- MEM:
  - dmem_req=1, dmem_we=1 for SW.
  - On dmem_ready: SW -> FETCH with pc_we=1, pc_src=00 in that cycle; LW -> WB.
- WB:
  - reg_we=1 except ADD/NAND with cond false.
  - Selects: LW wb_sel=01, reg_dst=0; ADD/NAND wb_sel=00, reg_dst=1; JAL wb_sel=10, reg_dst=0, pc_src=10.
  - pc_we=1 (pc_src 00 unless JAL) -> FETCH.
  - Takes one cycle.
- retired increments on every edge where pc_we=1, mod 2^CNT_WIDTH.
- Wait counter:
  - Cleared on each state change.
  - Increments each cycle a request is pending and ready=0.
  - With TIMEOUT>0, on the edge where it would reach TIMEOUT -> TRAP, cause 10 (FETCH) or 11 (MEM).
  - ready asserted in the same cycle as the final count wins; no trap.
- TRAP: all enables/requests 0, trap=1, ir, flags and retired frozen. Exit only via reset.
- Latency with zero wait states:
  - BEQ, SW: 2–3 cycles (BEQ 2, SW 3).
  - ADD/NAND, LW: 3–4 cycles (ADD/NAND 3, LW 4).
  - JAL: 2 cycles.

Test Plan:
- Reset, imem_ready=1, stream ADD 0x0050 -> state 0→1→3→0, reg_we=1 in WB, pc_we once, retired=1; with alu_carry=1, alu_zero=0 in EXEC -> c_flag=1, z_flag=0.
- c_flag=0, ADC 0x0052 -> WB with reg_we=0 and pc_we=1, flags unchanged, retired increments; repeat with c_flag=1 -> reg_we=1.
- LW 0xA285 with dmem_ready low 3 cycles, TIMEOUT=15 -> MEM held 4 cycles, then WB with wb_sel=01, total 7 cycles.
- FETCH with imem_ready held 0, TIMEOUT=15 -> TRAP at 15th edge, trap_cause=10; ready on 15th cycle instead -> no trap.
- Opcode 0xF000 -> TRAP, cause 01, outputs 0; assert reset mid-TRAP -> FETCH, retired=0.
- BEQ with alu_zero=1 -> pc_src=01. JAL 0xD003 -> FETCH→WB in 2 cycles with pc_src=10, wb_sel=10. Retired wraps with CNT_WIDTH=2 after 4 instructions -> 0.
